// File: rtl/sample_framer_pkg.sv
// Shared types and constants for the sample framer.
// Optional frame sequence header is enabled by defining SAMPLE_FRAMER_SEQ_EN.
package sample_framer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam int SEQ_BITS = 32;
    localparam int OVF_BITS = 16;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO: registered write, combinational head read.
// Extra pointer MSB distinguishes full from empty; a write into a full FIFO is taken if a pop frees a slot.
module sample_fifo #(
    parameter int WORD_BITS = 32,
    parameter int DEPTH     = 512
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [WORD_BITS-1:0] wr_data,
    input  logic                 rd_en,
    output logic [WORD_BITS-1:0] rd_data,
    output logic                 full,
    output logic                 empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WORD_BITS-1:0] mem [DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 wr_fire;
    logic                 rd_fire;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_fire = rd_en && !empty;
    assign wr_fire = wr_en && (!full || rd_fire);

    // NOTE: the storage array has no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/sample_framer.sv
// Buffers an unstallable sample strobe and releases fixed-length AXI-Stream frames once complete.
// Define SAMPLE_FRAMER_SEQ_EN to prefix each frame with a 32-bit sequence number beat.
module sample_framer
    import sample_framer_pkg::*;
#(
    parameter int WORD_BITS     = 32,
    parameter int PAYLOAD_WORDS = 128,
    parameter int DEPTH         = 512
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [WORD_BITS-1:0]                     in_data,
    input  logic                                     in_valid,
    output logic [WORD_BITS-1:0]                     m_axis_tdata,
    output logic                                     m_axis_tvalid,
    input  logic                                     m_axis_tready,
    output logic                                     m_axis_tlast,
    output logic [OVF_BITS-1:0]                      overflow_cnt,
    output logic [$clog2(DEPTH/PAYLOAD_WORDS):0]     frames_ready
);

    localparam int FR_BITS  = $clog2(DEPTH/PAYLOAD_WORDS) + 1;
    localparam int CNT_BITS = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;

`ifdef SAMPLE_FRAMER_SEQ_EN
    localparam int     FRAME_SAMPLES = PAYLOAD_WORDS - 1;
    localparam state_t FIRST_STATE   = HDR;
`else
    localparam int     FRAME_SAMPLES = PAYLOAD_WORDS;
    localparam state_t FIRST_STATE   = SEND;
`endif

    localparam logic [CNT_BITS-1:0] LAST_SAMPLE = CNT_BITS'(FRAME_SAMPLES - 1);
    localparam logic [CNT_BITS-1:0] LAST_BEAT   = CNT_BITS'(PAYLOAD_WORDS - 1);

    state_t               state;
    state_t               state_nxt;
    logic [CNT_BITS-1:0]  wr_cnt;
    logic [CNT_BITS-1:0]  rd_cnt;
    logic [FR_BITS-1:0]   frames_nxt;
    logic [WORD_BITS-1:0] fifo_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 handshake;
    logic                 last_hs;
    logic                 pop;
    logic                 wr_accept;
    logic                 frame_done;
`ifdef SAMPLE_FRAMER_SEQ_EN
    logic [SEQ_BITS-1:0]  seq;
`endif

    sample_fifo #(
        .WORD_BITS (WORD_BITS),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (in_valid),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (fifo_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Header beats handshake without popping; only SEND beats consume FIFO words.
    assign handshake  = m_axis_tvalid && m_axis_tready;
    assign last_hs    = handshake && m_axis_tlast;
    assign pop        = (state == SEND) && m_axis_tready && !fifo_empty;
    assign wr_accept  = in_valid && (!fifo_full || pop);
    assign frame_done = wr_accept && (wr_cnt == LAST_SAMPLE);

    always_comb begin
        frames_nxt = frames_ready;
        case ({frame_done, last_hs})
            2'b10:   frames_nxt = frames_ready + FR_BITS'(1);
            2'b01:   frames_nxt = frames_ready - FR_BITS'(1);
            default: frames_nxt = frames_ready;
        endcase
    end

    // Dropped samples never advance wr_cnt, so frame alignment survives overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            frames_ready <= '0;
            overflow_cnt <= '0;
        end else begin
            frames_ready <= frames_nxt;
            if (wr_accept) begin
                wr_cnt <= frame_done ? '0 : wr_cnt + 1'b1;
            end
            if (in_valid && !wr_accept && (overflow_cnt != '1)) begin
                overflow_cnt <= overflow_cnt + 1'b1;
            end
            if (handshake) begin
                rd_cnt <= last_hs ? '0 : rd_cnt + 1'b1;
            end
        end
    end

`ifdef SAMPLE_FRAMER_SEQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq <= '0;
        end else if (last_hs) begin
            seq <= seq + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (frames_ready != '0) state_nxt = FIRST_STATE;
            HDR:  if (handshake) state_nxt = SEND;
            SEND: if (last_hs) state_nxt = (frames_nxt != '0) ? FIRST_STATE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        case (state)
            SEND: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = (rd_cnt == LAST_BEAT);
                m_axis_tdata  = fifo_data;
            end
`ifdef SAMPLE_FRAMER_SEQ_EN
            HDR: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = WORD_BITS'(seq);
            end
`endif
            default: begin
                m_axis_tvalid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sample_framer.sv
// Directed bench for sample_framer with PAYLOAD_WORDS=4, DEPTH=8.
// Expectations follow SAMPLE_FRAMER_SEQ_EN when the bench is built with it.
module tb_sample_framer;

    localparam int WB = 32;
    localparam int PW = 4;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [WB-1:0] in_data;
    logic          in_valid;
    logic [WB-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [15:0]   overflow_cnt;
    logic [1:0]    frames_ready;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic          vld;
        logic [WB-1:0] din;
        logic          e_tv;
        logic [WB-1:0] e_td;
        logic          e_tl;
        int            e_fr;
    } vec_t;

    vec_t vecs[$];

    sample_framer #(
        .WORD_BITS     (WB),
        .PAYLOAD_WORDS (PW),
        .DEPTH         (DP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .overflow_cnt  (overflow_cnt),
        .frames_ready  (frames_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Outputs are sampled and inputs driven on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic add(input logic vld, input logic [WB-1:0] din, input logic tv,
                       input logic [WB-1:0] td, input logic tl, input int fr);
        vec_t v;
        v.vld = vld; v.din = din; v.e_tv = tv; v.e_td = td; v.e_tl = tl; v.e_fr = fr;
        vecs.push_back(v);
    endtask

    task automatic write_words(input logic [WB-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + WB'(i);
            step();
        end
        in_valid = 1'b0;
    endtask

    // Accepts one whole frame with tready high; max_wait=0 demands it is already valid.
    task automatic expect_frame(input string tag, input logic [WB-1:0] w0, input logic [WB-1:0] w1,
                                input logic [WB-1:0] w2, input logic [WB-1:0] w3, input int max_wait);
        logic [WB-1:0] w [4];
        int waited;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        m_axis_tready = 1'b1;
        waited = 0;
        while (!m_axis_tvalid && waited < max_wait) begin
            step();
            waited++;
        end
        check({tag, " tvalid start"}, 64'(m_axis_tvalid), 64'(1));
        for (int b = 0; b < 4; b++) begin
            check($sformatf("%s beat%0d tvalid", tag, b), 64'(m_axis_tvalid), 64'(1));
            check($sformatf("%s beat%0d tdata", tag, b), 64'(m_axis_tdata), 64'(w[b]));
            check($sformatf("%s beat%0d tlast", tag, b), 64'(m_axis_tlast), 64'(b == 3));
            step();
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_data       = '0;
        m_axis_tready = 1'b0;
        step();
        step();
        check("reset tvalid", 64'(m_axis_tvalid), 64'(0));
        check("reset tlast", 64'(m_axis_tlast), 64'(0));
        check("reset tdata", 64'(m_axis_tdata), 64'(0));
        check("reset overflow_cnt", 64'(overflow_cnt), 64'(0));
        check("reset frames_ready", 64'(frames_ready), 64'(0));
        rst_n = 1'b1;

`ifndef SAMPLE_FRAMER_SEQ_EN
        // Basic frame then a partial frame completed later, tready held high.
        add(1, 32'hA0, 0, 0, 0, 0);
        add(1, 32'hA1, 0, 0, 0, 0);
        add(1, 32'hA2, 0, 0, 0, 0);
        add(1, 32'hA3, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1);
        add(0, 0, 1, 32'hA0, 0, 1);
        add(0, 0, 1, 32'hA1, 0, 1);
        add(0, 0, 1, 32'hA2, 0, 1);
        add(0, 0, 1, 32'hA3, 1, 1);
        add(1, 32'hB0, 0, 0, 0, 0);
        add(1, 32'hB1, 0, 0, 0, 0);
        add(1, 32'hB2, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        add(1, 32'hB3, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1);
        add(0, 0, 1, 32'hB0, 0, 1);
        add(0, 0, 1, 32'hB1, 0, 1);
        add(0, 0, 1, 32'hB2, 0, 1);
        add(0, 0, 1, 32'hB3, 1, 1);
        add(0, 0, 0, 0, 0, 0);

        m_axis_tready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            check($sformatf("vec%0d tvalid", i), 64'(m_axis_tvalid), 64'(vecs[i].e_tv));
            if (vecs[i].e_tv)
                check($sformatf("vec%0d tdata", i), 64'(m_axis_tdata), 64'(vecs[i].e_td));
            check($sformatf("vec%0d tlast", i), 64'(m_axis_tlast), 64'(vecs[i].e_tl));
            check($sformatf("vec%0d frames_ready", i), 64'(frames_ready), 64'(vecs[i].e_fr));
            in_valid = vecs[i].vld;
            in_data  = vecs[i].din;
            step();
        end
        in_valid = 1'b0;

        // Backpressure mid-frame: 10 stalled cycles after the first beat.
        write_words(32'hC0, 4);
        for (int w = 0; w < 5 && !m_axis_tvalid; w++) step();
        check("bp first tvalid", 64'(m_axis_tvalid), 64'(1));
        check("bp first tdata", 64'(m_axis_tdata), 64'(32'hC0));
        step();
        m_axis_tready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            check($sformatf("bp stall%0d tvalid", c), 64'(m_axis_tvalid), 64'(1));
            check($sformatf("bp stall%0d tdata", c), 64'(m_axis_tdata), 64'(32'hC1));
            check($sformatf("bp stall%0d tlast", c), 64'(m_axis_tlast), 64'(0));
        end
        m_axis_tready = 1'b1;
        for (int b = 1; b < 4; b++) begin
            check($sformatf("bp beat%0d tdata", b), 64'(m_axis_tdata), 64'(32'hC0 + b));
            check($sformatf("bp beat%0d tlast", b), 64'(m_axis_tlast), 64'(b == 3));
            step();
        end
        check("bp end tvalid", 64'(m_axis_tvalid), 64'(0));
        check("bp end frames_ready", 64'(frames_ready), 64'(0));

        // Overflow: 10 writes into an 8-deep FIFO with the sink stalled.
        m_axis_tready = 1'b0;
        write_words(32'hD0, 10);
        step();
        check("ovf overflow_cnt", 64'(overflow_cnt), 64'(2));
        check("ovf frames_ready", 64'(frames_ready), 64'(2));
        check("ovf held tdata", 64'(m_axis_tdata), 64'(32'hD0));
        expect_frame("ovf f0", 32'hD0, 32'hD1, 32'hD2, 32'hD3, 0);
        expect_frame("ovf f1", 32'hD4, 32'hD5, 32'hD6, 32'hD7, 0);
        check("ovf end tvalid", 64'(m_axis_tvalid), 64'(0));
        check("ovf end frames_ready", 64'(frames_ready), 64'(0));
        check("ovf end overflow_cnt", 64'(overflow_cnt), 64'(2));

        // Frame 2 completes on the same edge as frame 1's tlast handshake.
        m_axis_tready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (c >= 5 && c <= 8) begin
                check($sformatf("sim c%0d tvalid", c), 64'(m_axis_tvalid), 64'(1));
                check($sformatf("sim c%0d tdata", c), 64'(m_axis_tdata), 64'(32'hE0 + (c - 5)));
                check($sformatf("sim c%0d tlast", c), 64'(m_axis_tlast), 64'(c == 8));
            end
            if (c >= 9 && c <= 12) begin
                check($sformatf("sim c%0d tvalid", c), 64'(m_axis_tvalid), 64'(1));
                check($sformatf("sim c%0d tdata", c), 64'(m_axis_tdata), 64'(32'hF0 + (c - 9)));
                check($sformatf("sim c%0d tlast", c), 64'(m_axis_tlast), 64'(c == 12));
            end
            if (c == 8 || c == 9)
                check($sformatf("sim c%0d frames_ready", c), 64'(frames_ready), 64'(1));
            if (c == 13) begin
                check("sim end tvalid", 64'(m_axis_tvalid), 64'(0));
                check("sim end frames_ready", 64'(frames_ready), 64'(0));
            end
            in_valid = (c < 4) || (c >= 5 && c < 9);
            in_data  = (c < 4) ? 32'hE0 + WB'(c) : 32'hF0 + WB'(c - 5);
            step();
        end
        in_valid = 1'b0;
`else
        // Header frames: each frame carries 3 samples behind a sequence number.
        write_words(32'h100, 6);
        check("seq frames_ready", 64'(frames_ready), 64'(2));
        check("seq hdr tvalid", 64'(m_axis_tvalid), 64'(1));
        expect_frame("seq f0", 32'd0, 32'h100, 32'h101, 32'h102, 0);
        expect_frame("seq f1", 32'd1, 32'h103, 32'h104, 32'h105, 0);
        check("seq end tvalid", 64'(m_axis_tvalid), 64'(0));
        check("seq end frames_ready", 64'(frames_ready), 64'(0));

        // Reset in the middle of the third frame.
        write_words(32'h200, 3);
        m_axis_tready = 1'b1;
        for (int w = 0; w < 5 && !m_axis_tvalid; w++) step();
        check("seq f2 hdr tvalid", 64'(m_axis_tvalid), 64'(1));
        check("seq f2 hdr tdata", 64'(m_axis_tdata), 64'(2));
        step();
        check("seq f2 beat1 tdata", 64'(m_axis_tdata), 64'(32'h200));
        step();
        rst_n = 1'b0;
        #1;
        check("mid reset tvalid", 64'(m_axis_tvalid), 64'(0));
        check("mid reset tdata", 64'(m_axis_tdata), 64'(0));
        check("mid reset frames_ready", 64'(frames_ready), 64'(0));
        step();
        rst_n = 1'b1;
        m_axis_tready = 1'b0;
        write_words(32'h300, 3);
        expect_frame("seq after reset", 32'd0, 32'h300, 32'h301, 32'h302, 5);
        check("seq after reset overflow_cnt", 64'(overflow_cnt), 64'(0));
`endif

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
